sw_ctrl: RTL
============

SW_CTRL -- requirements
Module: sw_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 100000000, clk_in cycles per count tick (legal range 2..2^27).
REQ-002 SHALL have port clk_in, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port btn_start, input, 1, start/stop button (asynchronous level, active-high).
REQ-005 SHALL have port btn_clr, input, 1, clear button (asynchronous level, active-high).
REQ-006 SHALL have port btn_lap, input, 1, lap/split button (asynchronous level, active-high).
REQ-007 SHALL have port tick, output, 1, one-cycle count-enable pulse to the digit counters.
REQ-008 SHALL have port clr, output, 1, one-cycle synchronous clear pulse to the digit counters.
REQ-009 SHALL have port run, output, 1, high while time is accumulating (RUN or LAP).
REQ-010 SHALL have port hold, output, 1, high while the display is frozen (LAP).
REQ-011 SHALL have port state, output, 2, FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer followed by rising-edge detection; one press yields exactly one 1-cycle event regardless of hold duration.
REQ-013 A button first sampled high at clk_in edge N SHALL produce a visible state change at edge N+3.
REQ-014 Prescaler SHALL count 0..DIV-1 only in RUN or LAP; tick SHALL be 1 for exactly the cycle after prescaler reaches DIV-1, with prescaler wrapping to 0.
REQ-015 Prescaler SHALL hold its value in PAUSE; no partial interval is lost or double-counted across pause/resume.
REQ-016 IDLE: start event -> RUN; clr event -> stay IDLE, clr pulse issued; lap event ignored.
REQ-017 RUN: start event -> PAUSE; lap event -> LAP; clr event ignored.
REQ-018 PAUSE: start event -> RUN; clr event -> IDLE, clr pulse issued, prescaler cleared to 0; lap event ignored.
REQ-019 LAP: lap event -> RUN; start event -> PAUSE; clr event ignored; tick continues at normal rate.
REQ-020 Simultaneous events in the same cycle SHALL be resolved with priority start > clr > lap; lower-priority events are discarded.
REQ-021 run SHALL equal (state==RUN or state==LAP); hold SHALL equal (state==LAP); both registered-state decodes with no glitch.
REQ-022 clr SHALL be asserted for exactly one cycle, coincident with the cycle the FSM registers IDLE from a clear event; never asserted with tick.
REQ-023 Prescaler SHALL be ceil(log2(DIV)) bits wide; no other arithmetic.

Reset
REQ-024 rst high SHALL immediately force state=IDLE, prescaler=0, synchronizer and edge-detect flops=0, tick=0, clr=0, run=0, hold=0, independent of clk_in.
REQ-025 Reset mid-operation (any state) SHALL abandon the current interval; a button held high through reset deassertion SHALL NOT generate an event.
REQ-026 Block SHALL NOT issue clr at reset; downstream counters are reset by rst directly.

Configuration
REQ-027 Macro SW_LAP_EN SHALL, when defined, enable the LAP state and btn_lap handling as above.
REQ-028 Without SW_LAP_EN, btn_lap SHALL remain a port but be ignored, LAP SHALL be unreachable, and hold SHALL be constant 0.

Verification (DIV=4)
REQ-029 rst pulse mid-RUN -> outputs all 0, state=00 immediately; btn_start held through reset release -> no transition.
REQ-030 btn_start pressed from IDLE, held 10 cycles -> state=01 at edge N+3, one event only, tick every 4th cycle thereafter.
REQ-031 RUN, prescaler=2, btn_start -> PAUSE; wait 20 cycles -> no tick; btn_start -> RUN, first tick 2 cycles after resume.
REQ-032 PAUSE, btn_start and btn_clr same cycle -> RUN, no clr pulse; PAUSE then btn_clr alone -> IDLE with single clr pulse, prescaler=0.
REQ-033 SW_LAP_EN defined: RUN, btn_lap -> state=11, hold=1, tick continues every 4 cycles; btn_lap -> state=01, hold=0.
REQ-034 SW_LAP_EN undefined: RUN, btn_lap pulse -> state stays 01, hold stays 0.

Source files
------------

// File: rtl/sw_ctrl.sv
// sw_ctrl: stopwatch control block.
// Synchronizes the start/clear/lap buttons, runs the IDLE/RUN/PAUSE/LAP state
// machine and divides clk_in by DIV to produce the count-enable tick for the
// digit counters.
// Optional feature: define SW_LAP_EN to enable the LAP (split) state and
// btn_lap handling. Without it btn_lap is ignored and hold is tied low.
module sw_ctrl #(
  parameter int unsigned DIV = 100000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic       tick,
  output logic       clr,
  output logic       run,
  output logic       hold,
  output logic [1:0] state
);

  localparam int unsigned   PW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
`ifdef SW_LAP_EN
  localparam logic          LAP_EN   = 1'b1;
`else
  localparam logic          LAP_EN   = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  // Button vectors are indexed 0 = start, 1 = clr, 2 = lap.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    edge_q;
  logic [2:0]    evt_d;
  logic [2:0]    evt_q;
  logic [2:0]    settle_d;
  logic [2:0]    settle_q;
  logic          start_ev;
  logic          clr_ev;
  logic          lap_ev;
  state_t        state_d;
  state_t        state_q;
  logic [PW-1:0] presc_d;
  logic [PW-1:0] presc_q;
  logic          tick_d;
  logic          tick_q;
  logic          clr_d;
  logic          clr_q;
  logic          run_d;
  logic          run_q;
`ifdef SW_LAP_EN
  logic          hold_d;
  logic          hold_q;
`endif

  assign btn_raw = {btn_lap, btn_clr, btn_start};

  // Rising-edge detect on the synchronized level. Edges are masked until the
  // synchronizer has refilled after reset, so a button held through reset
  // release looks like a steady level rather than a fresh press.
  always_comb begin
    evt_d    = sync2_q & ~edge_q & {3{settle_q[2]}};
    settle_d = {settle_q[1:0], 1'b1};
  end

  // Two-flop synchronizer, edge-detect history and registered button events.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      edge_q   <= '0;
      evt_q    <= '0;
      settle_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      edge_q   <= sync2_q;
      evt_q    <= evt_d;
      settle_q <= settle_d;
    end
  end

  // Fixed priority start > clr > lap: only the winning event is acted upon.
  assign start_ev = evt_q[0];
  assign clr_ev   = evt_q[1] & ~evt_q[0];
  assign lap_ev   = evt_q[2] & LAP_EN & ~evt_q[1] & ~evt_q[0];

  // Next-state, clear pulse, prescaler and output decode.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    presc_d = presc_q;
    tick_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          state_d = S_RUN;
        end else if (clr_ev) begin
          clr_d = 1'b1;
        end
      end
      S_RUN: begin
        if (start_ev) begin
          state_d = S_PAUSE;
        end else if (lap_ev) begin
          state_d = S_LAP;
        end
      end
      S_PAUSE: begin
        if (start_ev) begin
          state_d = S_RUN;
        end else if (clr_ev) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
      end
      S_LAP: begin
        if (start_ev) begin
          state_d = S_PAUSE;
        end else if (lap_ev) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The prescaler advances only while time accumulates and is frozen in
    // PAUSE, so a partial interval survives pause/resume intact.
    if ((state_q == S_RUN) || (state_q == S_LAP)) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (clr_d) begin
      presc_d = '0;
    end

    run_d = (state_d == S_RUN) || (state_d == S_LAP);
`ifdef SW_LAP_EN
    hold_d = (state_d == S_LAP);
`endif
  end

  // State register with all outputs registered alongside it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
`ifdef SW_LAP_EN
      hold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      run_q   <= run_d;
`ifdef SW_LAP_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign tick  = tick_q;
  assign clr   = clr_q;
  assign run   = run_q;
  assign state = state_q;
`ifdef SW_LAP_EN
  assign hold  = hold_q;
`else
  assign hold  = 1'b0;
`endif

endmodule
